// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_e;

   localparam logic [3:0] COL_RESET = 4'b1110;

   // Keypad legend: r0: 1 2 3 A, r1: 4 5 6 B, r2: 7 8 9 C, r3: E 0 F D
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'hE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hF;
         4'hF:    code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   // Index of the lowest active-low row; only meaningful when some row is low.
   function automatic logic [1:0] first_low(input logic [3:0] rows);
      logic [1:0] idx;
      if (!rows[0])      idx = 2'd0;
      else if (!rows[1]) idx = 2'd1;
      else if (!rows[2]) idx = 2'd2;
      else               idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan tick divider: tick is high for one clk every SCAN_DIV clks.
module keypad_tick_gen #(
   parameter int unsigned SCAN_DIV = 50_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) cnt_d = '0;
   end

   // tick is registered so it is high exactly while cnt_q sits at LAST
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_d == LAST);
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with press/release debounce and hex decode.
// Define KEYPAD_DIGITS_EN to build the 32-bit accepted-digit shift register.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50_000,
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [31:0] digits
);

   localparam int unsigned DBC_W = $clog2(DEBOUNCE_CNT + 1);

   logic [3:0]       row_meta_q, row_sync_q;
   logic             tick;
   state_e           state_q, state_d;
   logic [3:0]       col_q, col_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [1:0]       row_q, row_d;
   logic [DBC_W-1:0] dbc_q, dbc_d;
   logic             key_valid_q, key_valid_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_held_q, key_held_d;
   logic             accept;

   logic             key_det, same_row, row_low, dbc_hit;
   logic [1:0]       det_row;
   logic [DBC_W-1:0] dbc_inc;

   keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Rows are asynchronous to clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         row_meta_q <= row_in;
         row_sync_q <= row_meta_q;
      end
   end

   assign key_det  = ~&row_sync_q;
   assign det_row  = first_low(row_sync_q);
   assign same_row = key_det && (det_row == row_q);
   assign row_low  = ~row_sync_q[row_q];
   assign dbc_inc  = dbc_q + DBC_W'(1);
   assign dbc_hit  = (dbc_inc == DBC_W'(DEBOUNCE_CNT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SCAN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (key_det) state_d = (DEBOUNCE_CNT == 1) ? HELD : DEBOUNCE;
            end
            DEBOUNCE: begin
               if (!same_row)    state_d = SCAN;
               else if (dbc_hit) state_d = HELD;
            end
            HELD: begin
               if (!row_low && dbc_hit) state_d = SCAN;
            end
            default: state_d = SCAN;
         endcase
      end
   end

   // Column rotation, debounce counting and the accept event
   always_comb begin
      col_d       = col_q;
      col_idx_d   = col_idx_q;
      row_d       = row_q;
      dbc_d       = dbc_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      key_held_d  = key_held_q;
      accept      = 1'b0;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (key_det) begin
                  row_d = det_row;
                  dbc_d = DBC_W'(1);
                  if (DEBOUNCE_CNT == 1) accept = 1'b1;
               end else begin
                  col_d     = {col_q[2:0], col_q[3]};
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (!same_row) begin
                  dbc_d     = '0;
                  col_d     = {col_q[2:0], col_q[3]};
                  col_idx_d = col_idx_q + 2'd1;
               end else if (dbc_hit) begin
                  accept = 1'b1;
               end else begin
                  dbc_d = dbc_inc;
               end
            end
            HELD: begin
               if (row_low) begin
                  dbc_d = '0;
               end else if (dbc_hit) begin
                  dbc_d      = '0;
                  key_held_d = 1'b0;
                  col_d      = {col_q[2:0], col_q[3]};
                  col_idx_d  = col_idx_q + 2'd1;
               end else begin
                  dbc_d = dbc_inc;
               end
            end
            default: dbc_d = '0;
         endcase
      end
      if (accept) begin
         key_code_d  = key_map(row_d, col_idx_q);
         key_valid_d = 1'b1;
         key_held_d  = 1'b1;
         dbc_d       = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q       <= COL_RESET;
         col_idx_q   <= 2'd0;
         row_q       <= 2'd0;
         dbc_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         key_held_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         col_idx_q   <= col_idx_d;
         row_q       <= row_d;
         dbc_q       <= dbc_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
      end
   end

`ifdef KEYPAD_DIGITS_EN
   logic [31:0] digits_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         digits_q <= 32'h0;
      else if (accept) digits_q <= {digits_q[27:0], key_code_d};
   end

   assign digits = digits_q;
`else
   assign digits = 32'h0;
`endif

   assign col_out   = col_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 keypad model.
module tb_keypad_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [31:0] digits;

   logic [3:0]  pr [4];
   int          total = 0;
   int          bad = 0;
   int          pulses = 0;
   logic [31:0] dig_model = 32'h0;

   typedef struct {
      int         r;
      int         c;
      int         r2;
      int         c2;
      bit         two;
      int         hold;
      logic [3:0] code;
   } vec_t;

   vec_t vt [7];

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_held  (key_held),
      .digits    (digits)
   );

   always #5 clk = ~clk;

   // Pressed switch (r,c) pulls row r low while column c is driven low
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pr[r][c] && !col_out[c]) row_in[r] = 1'b0;
   end

   always @(negedge clk) if (key_valid) pulses <= pulses + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] exp_dig();
`ifdef KEYPAD_DIGITS_EN
      return dig_model;
`else
      return 32'h0;
`endif
   endfunction

   task automatic release_all();
      for (int r = 0; r < 4; r++) pr[r] = 4'h0;
   endtask

   initial begin
      int          base;
      bit          held_drop;
      bit          found;
      logic [3:0]  ec;
      logic [3:0]  prev;

      vt[0] = '{r:1, c:1, r2:0, c2:0, two:0, hold:40,  code:4'h5};
      vt[1] = '{r:0, c:0, r2:0, c2:0, two:0, hold:40,  code:4'h1};
      vt[2] = '{r:0, c:3, r2:0, c2:0, two:0, hold:40,  code:4'hA};
      vt[3] = '{r:3, c:1, r2:0, c2:0, two:0, hold:40,  code:4'h0};
      vt[4] = '{r:3, c:3, r2:0, c2:0, two:0, hold:40,  code:4'hD};
      vt[5] = '{r:0, c:2, r2:2, c2:2, two:1, hold:40,  code:4'h3};
      vt[6] = '{r:2, c:1, r2:0, c2:0, two:0, hold:200, code:4'h8};

      release_all();
      rst = 1'b1;
      #1;
      check("rst_col",   32'(col_out),   32'hE);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_code",  32'(key_code),  32'h0);
      check("rst_held",  32'(key_held),  32'h0);
      check("rst_dig",   digits,         32'h0);
      clks(3);
      rst = 1'b0;

      // Idle scan: one rotation per 4 clks starting from column 0
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         ec = 4'b1110;
         repeat (i / 4) ec = {ec[2:0], ec[3]};
         check($sformatf("rot%0d", i), 32'(col_out), 32'(ec));
      end

      for (int v = 0; v < 7; v++) begin
         base = pulses;
         held_drop = 1'b0;
         pr[vt[v].r][vt[v].c] = 1'b1;
         if (vt[v].two) pr[vt[v].r2][vt[v].c2] = 1'b1;
         for (int k = 0; k < vt[v].hold; k++) begin
            @(negedge clk);
            if (pulses > base + 1 || (pulses > base && !key_held)) held_drop = 1'b1;
         end
         dig_model = {dig_model[27:0], vt[v].code};
         check($sformatf("v%0d_pulses", v), 32'(pulses - base), 32'd1);
         check($sformatf("v%0d_code", v),   32'(key_code),      32'(vt[v].code));
         check($sformatf("v%0d_held", v),   32'(key_held),      32'd1);
         check($sformatf("v%0d_steady", v), 32'(held_drop),     32'd0);
         check($sformatf("v%0d_digits", v), digits,             exp_dig());
         release_all();
         clks(6);
         check($sformatf("v%0d_held_early", v), 32'(key_held), 32'd1);
         clks(24);
         check($sformatf("v%0d_released", v), 32'(key_held),      32'd0);
         check($sformatf("v%0d_no_rel", v),   32'(pulses - base), 32'd1);
      end

      // Bounce: low for one tick on column 0, then high, then stable low
      found = 1'b0;
      prev = col_out;
      for (int k = 0; k < 64 && !found; k++) begin
         @(negedge clk);
         if (col_out == 4'b1110 && prev != 4'b1110) found = 1'b1;
         prev = col_out;
      end
      check("bounce_sync", 32'(found), 32'd1);
      base = pulses;
      pr[1][0] = 1'b1;
      clks(4);
      pr[1][0] = 1'b0;
      clks(4);
      check("bounce_glitch", 32'(pulses - base), 32'd0);
      pr[1][0] = 1'b1;
      clks(60);
      dig_model = {dig_model[27:0], 4'h4};
      check("bounce_pulses", 32'(pulses - base), 32'd1);
      check("bounce_code",   32'(key_code),      32'h4);
      check("bounce_digits", digits,             exp_dig());
      release_all();
      clks(30);

      // Reset while key_valid is high, then re-detection of the held key
      pr[1][2] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 64 && !found; k++) begin
         @(negedge clk);
         if (key_valid) found = 1'b1;
      end
      check("mid_wait", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_col",   32'(col_out),   32'hE);
      check("mid_valid", 32'(key_valid), 32'h0);
      check("mid_code",  32'(key_code),  32'h0);
      check("mid_held",  32'(key_held),  32'h0);
      check("mid_dig",   digits,         32'h0);
      clks(3);
      rst = 1'b0;
      dig_model = 32'h0;
      base = pulses;
      clks(40);
      dig_model = {dig_model[27:0], 4'h6};
      check("re_pulses", 32'(pulses - base), 32'd1);
      check("re_code",   32'(key_code),      32'h6);
      check("re_held",   32'(key_held),      32'd1);
      check("re_digits", digits,             exp_dig());
      release_all();
      clks(30);
      check("re_released", 32'(key_held), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
